muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Sequential multiply/divide unit owning the MIPS150 HI/LO register pair, beside the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs 32-cycle iterative multiply (shift-add) or divide (restoring). It holds the 64-bit result in HI/LO for MFHI/MFLO reads. It asserts `busy` so the hazard logic can stall the pipeline.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command valid; sampled at a rising edge only while `busy`=0.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op).
- `a` in 32: rs operand (multiplicand / dividend / MTHI/MTLO data).
- `b` in 32: rt operand (multiplier / divisor).
- `busy` out 1: operation in flight; HI/LO not valid.
- `done` out 1: one-cycle pulse after HI/LO update from MULT/DIV.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`=1:
  - op 0/1 goes to MUL; op 2/3 goes to DIV.
  - Operands are latched. For signed ops, the magnitudes are latched and the result sign is recorded (product: a[31]^b[31]; quotient: a[31]^b[31]; remainder: a[31]).
  - op 4/5 writes `a` into HI or LO at that edge and stays in IDLE. `busy` stays 0 and `done` is not pulsed.
  - op 6/7 has no effect.
- MUL: 32 iterations of shift-add on the unsigned 64-bit accumulator, one bit per cycle, LSB first.
- DIV: 32 iterations of restoring division, one quotient bit per cycle, MSB first. The partial remainder is 33 bits wide.
- FIX: applies two's-complement negation per the recorded signs, writes HI/LO, then returns to IDLE.
  - Unsigned ops pass through FIX unchanged.
- Results:
  - Multiply: {hi,lo} = full 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a (raw, no sign correction). This still takes the full latency.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The upstream stall guarantees it is not issued.
- HI/LO hold their previous values throughout MUL/DIV and change only at the FIX edge.

## Timing
- Accept edge E0 (start=1, busy=0): `busy`=1 from after E0.
- Iteration edges E1..E32, then the FIX edge E33.
- At E33 HI/LO are written and `busy`=0.
- `done`=1 during the cycle after E33 only.
- Latency from start edge to valid HI/LO is 33 cycles. Back-to-back accept is possible at E33+1 (the cycle `done` is high).
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the accept edge.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- `rst` mid-operation aborts at that edge. The result is discarded, HI/LO are cleared to 0 and no `done` pulse follows.
- `rst` and `start` at the same edge: reset wins.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 64-bit `*` product computed at the accept edge.
  - State goes IDLE to FIX directly, so HI/LO are valid after E1.
  - `busy` is high for exactly one cycle and `done` pulses in the cycle after E1.
  - DIV/DIVU are unchanged.
- Undefined: multiply is iterative with 33-cycle latency, the same as divide.

## Test plan
- Reset: assert `rst` 2 cycles -> hi=0, lo=0, busy=0, done=0.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 cycles hi=32'hFFFFFFFE, lo=32'h00000001, one `done` pulse. With `MULDIV_FAST_MUL_EN`, the same values after 1 cycle.
- Signed divides:
  - DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100.
- MTHI a=32'h12345678 then MTLO a=32'h9ABCDEF0 on consecutive cycles -> hi and lo take those values one cycle after each; busy stays 0; no `done`.
- MULT a=-3, b=5 started; `rst` at cycle 10 -> hi=lo=0, busy=0, no `done`. A new start during busy (before the reset) leaves the in-flight result unaffected.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// ----------------------------------------------------------------------------
// muldiv_hilo_if
// Command/result bundle between the execute stage and the HI/LO multiply/divide
// unit.
//   start  : command valid; sampled only while busy is low
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a, b   : rs / rt operands
//   busy   : operation in flight; HI/LO not yet valid
//   done   : one-cycle pulse after HI/LO are written by a MULT/DIV
//   hi, lo : HI and LO registers
// Modports: master = execute stage side, slave = muldiv_hilo side.
// ----------------------------------------------------------------------------
interface muldiv_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// ----------------------------------------------------------------------------
// muldiv_hilo
// Sequential multiply/divide unit owning the HI/LO register pair.
//   MULT/MULTU : 32-cycle shift-add multiply, LSB first, {hi,lo} = product
//   DIV/DIVU   : 32-cycle restoring divide, MSB first, lo = quot, hi = rem
//   MTHI/MTLO  : write a into HI/LO at the accept edge, no busy, no done
// Signed operations run on magnitudes; a final FIX cycle applies the recorded
// signs and writes HI/LO. Total latency from accept edge to valid HI/LO is 33
// cycles.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears HI/LO, aborts any operation)
//   bus : muldiv_hilo_if.slave (start/op/a/b in, busy/done/hi/lo out)
// Configuration macro:
//   MULDIV_FAST_MUL_EN : MULT/MULTU use a single-cycle product at the accept
//                        edge and go straight to FIX (busy for one cycle).
// ----------------------------------------------------------------------------
module muldiv_hilo (
    input  logic          clk,
    input  logic          rst,
    muldiv_hilo_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] acc_reg;        // product accumulator
    logic [63:0] mcand_reg;      // multiplicand, shifted left each iteration
    logic [31:0] mplier_reg;     // multiplier, shifted right each iteration
    logic [31:0] rem_reg;        // partial remainder (always < divisor)
    logic [31:0] quot_reg;       // dividend bits shift out, quotient bits in
    logic [31:0] divisor_reg;
    logic [31:0] raw_a_reg;      // untouched dividend for divide-by-zero
    logic        neg_p_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        div_zero_reg;
    logic        is_div_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        op_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
        a_mag     = (op_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        b_mag     = (op_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;

    always_comb begin
        if (bus.op == 3'd0)
            fast_prod = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
        else
            fast_prod = {32'd0, bus.a} * {32'd0, bus.b};
    end
`endif

    // ------------------------------------------------------------------
    // Restoring divide step: the 33-bit trial value is the remainder with
    // the next dividend bit shifted in; subtract when it covers the divisor.
    // A zero divisor always subtracts, giving an all-ones quotient.
    // ------------------------------------------------------------------
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_take;

    always_comb begin
        div_shift = {rem_reg, quot_reg[31]};
        div_diff  = div_shift - {1'b0, divisor_reg};
        div_take  = (div_shift >= {1'b0, divisor_reg});
    end

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [63:0] mul_res;
    logic [31:0] quot_res;
    logic [31:0] rem_res;

    always_comb begin
        mul_res  = neg_p_reg ? (64'd0 - acc_reg) : acc_reg;
        quot_res = neg_q_reg ? (32'd0 - quot_reg) : quot_reg;
        rem_res  = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 5'd0;
            acc_reg      <= 64'd0;
            mcand_reg    <= 64'd0;
            mplier_reg   <= 32'd0;
            rem_reg      <= 32'd0;
            quot_reg     <= 32'd0;
            divisor_reg  <= 32'd0;
            raw_a_reg    <= 32'd0;
            neg_p_reg    <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            is_div_reg   <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1: begin
`ifdef MULDIV_FAST_MUL_EN
                                acc_reg   <= fast_prod;
                                neg_p_reg <= 1'b0;
                                state_reg <= FIX;
`else
                                acc_reg    <= 64'd0;
                                mcand_reg  <= {32'd0, a_mag};
                                mplier_reg <= b_mag;
                                neg_p_reg  <= op_signed & (bus.a[31] ^ bus.b[31]);
                                state_reg  <= MUL;
`endif
                                is_div_reg <= 1'b0;
                                cnt_reg    <= 5'd0;
                                busy_reg   <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                rem_reg      <= 32'd0;
                                quot_reg     <= a_mag;
                                divisor_reg  <= b_mag;
                                raw_a_reg    <= bus.a;
                                div_zero_reg <= (bus.b == 32'd0);
                                neg_q_reg    <= op_signed & (bus.a[31] ^ bus.b[31]);
                                neg_r_reg    <= op_signed & bus.a[31];
                                is_div_reg   <= 1'b1;
                                cnt_reg      <= 5'd0;
                                busy_reg     <= 1'b1;
                                state_reg    <= DIV;
                            end
                            3'd4:    hi_reg <= bus.a;
                            3'd5:    lo_reg <= bus.a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (mplier_reg[0])
                        acc_reg <= acc_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        state_reg <= FIX;
                end
                DIV: begin
                    rem_reg  <= div_take ? div_diff[31:0] : div_shift[31:0];
                    quot_reg <= {quot_reg[30:0], div_take};
                    cnt_reg  <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        state_reg <= FIX;
                end
                FIX: begin
                    if (!is_div_reg) begin
                        hi_reg <= mul_res[63:32];
                        lo_reg <= mul_res[31:0];
                    end else if (div_zero_reg) begin
                        // Divide by zero reports the raw dividend, no sign fix.
                        hi_reg <= raw_a_reg;
                        lo_reg <= 32'hFFFF_FFFF;
                    end else begin
                        hi_reg <= rem_res;
                        lo_reg <= quot_res;
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// ----------------------------------------------------------------------------
// tb_muldiv_hilo
// Directed-vector bench for muldiv_hilo. Inputs change and outputs are sampled
// on the falling clock edge. One line is printed per transaction.
// ----------------------------------------------------------------------------
module tb_muldiv_hilo;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic rst;

    muldiv_hilo_if bus ();

    muldiv_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one MULT/DIV command (caller is at a falling edge) and waits for
    // done. Optionally injects an MTLO while busy, which must be ignored.
    // Returns at the falling edge where done is high, so a following call
    // exercises back-to-back accept.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit intrude);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
        n = 0;
        while (n < 100) begin
            if (intrude && n == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd5;
                bus.a     = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (n == 16 && lat > 16)
                check({tag, "_hold"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
            if (bus.done)
                break;
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_res"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        check({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
        $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h (%0d cycles)",
                 tag, op, a, b, bus.hi, bus.lo, n);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        int  n;
        bit  seen_done;
        tests_run    = 0;
        tests_failed = 0;
        prev_hi      = 32'd0;
        prev_lo      = 32'd0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        // Reset
        repeat (2) @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Multiplies
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, MUL_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, MUL_LAT,
               32'h4000_0000, 32'h0000_0000, 1'b0);

        // Divides (back-to-back with the multiplies above)
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, DIV_LAT,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
               32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, DIV_LAT,
               32'd2, 32'd14, 1'b0);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, DIV_LAT,
               32'd100, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, DIV_LAT,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

        // done is a single-cycle pulse
        @(negedge clk);
        check("done_pulse", {63'd0, bus.done}, 64'd0);

        // MTHI then MTLO on consecutive cycles
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h1234_5678});
        check("mthi_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.op = 3'd5;
        bus.a  = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'h1234_5678, 32'h9ABC_DEF0});
        check("mtlo_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        $display("[TB] mthi/mtlo -> hi=%h lo=%h", bus.hi, bus.lo);

        // Reserved op is a no-op
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.a     = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        check("reserved_op", {bus.hi, bus.lo, 32'd0} >> 32, {32'h1234_5678, 32'h9ABC_DEF0});
        check("reserved_busy", {63'd0, bus.busy}, 64'd0);
        $display("[TB] reserved op=6 -> hi=%h lo=%h", bus.hi, bus.lo);

        // Reset in the middle of an operation
        bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        bus.op = 3'd2;
`else
        bus.op = 3'd0;
`endif
        bus.a = 32'hFFFF_FFFD;
        bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        seen_done = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done)
                seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        $display("[TB] reset mid-op -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

        // Reset and start at the same edge: reset wins
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'hA5A5_A5A5;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_start_busy", {63'd0, bus.busy}, 64'd0);
        $display("[TB] reset+MTHI same edge -> hi=%h", bus.hi);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
